// File: rtl/iter_mdu_pkg.sv
// -----------------------------------------------------------------------------
// iter_mdu_pkg
// Shared definitions for the iterative multiply/divide/accumulate unit:
//   - MDU_WIDTH   : default operand width
//   - mdu_op_e    : MDU operation encodings (same numbering as the EX op field)
//   - mdu_state_e : sequencer state encodings
//   - small decode helpers used by the datapath
// -----------------------------------------------------------------------------
package iter_mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MADD  = 3'd4,
        MDU_MADDU = 3'd5,
        MDU_MSUB  = 3'd6,
        MDU_MSUBU = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_BUSY = 2'd1,
        MDU_ST_FIX  = 2'd2,
        MDU_ST_DONE = 2'd3
    } mdu_state_e;

    // Every signed op has an even encoding (MULT, DIV, MADD, MSUB).
    function automatic logic mdu_is_signed(input mdu_op_e op);
        logic [2:0] code;
        code = op;
        return ~code[0];
    endfunction

    function automatic logic mdu_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_madd(input mdu_op_e op);
        return (op == MDU_MADD) || (op == MDU_MADDU);
    endfunction

    function automatic logic mdu_is_msub(input mdu_op_e op);
        return (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

endpackage

// File: rtl/iter_mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational conditional two's-complement negation, LANES lanes wide.
// Used on the operand side to take magnitudes (neg = signed op & sign bit)
// and on the result side to restore signs after the unsigned iteration.
// Ports:
//   val   in  LANES x W  values to fix
//   neg   in  LANES      per-lane negate request
//   fixed out LANES x W  neg ? -val : val  (mod 2^W)
// -----------------------------------------------------------------------------
module mdu_sign_fix
    import iter_mdu_pkg::*;
#(
    parameter int W     = MDU_WIDTH,
    parameter int LANES = 2
) (
    input  logic [LANES-1:0][W-1:0] val,
    input  logic [LANES-1:0]        neg,
    output logic [LANES-1:0][W-1:0] fixed
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Negating the most-negative value wraps to itself, which is the
            // correct magnitude when read back as unsigned.
            assign fixed[gi] = neg[gi] ? ({W{1'b0}} - val[gi]) : val[gi];
        end
    endgenerate

endmodule

// File: rtl/iter_mdu.sv
// -----------------------------------------------------------------------------
// iter_mdu
// Iterative radix-2 multiply / divide / multiply-accumulate unit for EX.
// One shift-add (multiply) or restoring (divide) step per cycle on operand
// magnitudes, followed by a single sign-fix/accumulate cycle.
//
// Build option:
//   MDU_ACCUM_EN defined   : ops 4-7 are MADD/MADDU/MSUB/MSUBU using hi_i/lo_i.
//   MDU_ACCUM_EN undefined : accumulate path omitted; 4,6 act as MULT and
//                            5,7 as MULTU; hi_i/lo_i are ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start_i    in   start request, accepted only in IDLE (and not with annul_i)
//   annul_i    in   flush an in-flight op (BUSY/FIX); blocks start in IDLE
//   op_i       in   operation code (see mdu_op_e)
//   opdata1_i  in   multiplicand / dividend
//   opdata2_i  in   multiplier / divisor
//   hi_i/lo_i  in   forwarded HI/LO for accumulate ops, sampled at start
//   result_o   out  {HI,LO}: {high,low} product or {remainder,quotient}
//   ready_o    out  one-cycle pulse, result_o valid
//   busy_o     out  high while iterating or fixing up (EX stall)
//   div_zero_o out  pulses with ready_o for a zero divisor
// -----------------------------------------------------------------------------
module iter_mdu
    import iter_mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic [WIDTH-1:0]     lo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int W2 = 2 * WIDTH;

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [W2-1:0]    acc_reg, acc_next;      // {upper, lower} working register
    logic [WIDTH-1:0] opnd_reg, opnd_next;    // multiplicand or divisor magnitude
    mdu_op_e          op_reg, op_next;
    logic             sign1_reg, sign1_next;
    logic             sign2_reg, sign2_next;
    logic             dz_reg, dz_next;
    logic [W2-1:0]    result_reg, result_next;

`ifdef MDU_ACCUM_EN
    logic [W2-1:0]    hilo_reg, hilo_next;
`else
    logic             unused_hilo;
    assign unused_hilo = ^{hi_i, lo_i};
`endif

    // ------------------------------------------------------------------
    // Incoming op decode and operand magnitudes
    // ------------------------------------------------------------------
    mdu_op_e op_in;
    always_comb begin
`ifdef MDU_ACCUM_EN
        op_in = mdu_op_e'(op_i);
`else
        // Without accumulate, fold ops 4-7 onto MULT/MULTU by their LSB.
        op_in = op_i[2] ? mdu_op_e'({2'b00, op_i[0]}) : mdu_op_e'(op_i);
`endif
    end

    logic in_signed, in_div, neg1, neg2;
    assign in_signed = mdu_is_signed(op_in);
    assign in_div    = mdu_is_div(op_in);
    assign neg1      = in_signed & opdata1_i[WIDTH-1];
    assign neg2      = in_signed & opdata2_i[WIDTH-1];

    logic [1:0][WIDTH-1:0] opnd_abs;
    mdu_sign_fix #(.W(WIDTH), .LANES(2)) u_opnd_fix (
        .val   ({opdata2_i, opdata1_i}),
        .neg   ({neg2, neg1}),
        .fixed (opnd_abs)
    );

    // ------------------------------------------------------------------
    // Iteration step datapath
    // ------------------------------------------------------------------
    logic             reg_div;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_step;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [W2-1:0]    div_step;

    assign reg_div = mdu_is_div(op_reg);

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the carry back in.
    assign mul_sum  = {1'b0, acc_reg[W2-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide: remainder needs one extra bit after the shift
    // because it can momentarily reach up to 2*divisor-1.
    assign div_shift = {acc_reg[W2-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_ge    = (div_shift >= {1'b0, opnd_reg});
    assign div_step  = div_ge ? {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Result sign fix: lane 0 is the product or the remainder,
    // lane 1 is the quotient.
    // ------------------------------------------------------------------
    logic [1:0][W2-1:0] res_in, res_fix;
    logic [1:0]         res_neg;
    logic               unused_res;

    assign res_in[0]  = reg_div ? {{WIDTH{1'b0}}, acc_reg[W2-1:WIDTH]} : acc_reg;
    assign res_in[1]  = {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]};
    // Remainder follows the dividend's sign; product and quotient use the XOR.
    assign res_neg[0] = reg_div ? sign1_reg : (sign1_reg ^ sign2_reg);
    assign res_neg[1] = sign1_reg ^ sign2_reg;
    assign unused_res = ^res_fix[1][W2-1:WIDTH];

    mdu_sign_fix #(.W(W2), .LANES(2)) u_res_fix (
        .val   (res_in),
        .neg   (res_neg),
        .fixed (res_fix)
    );

    logic [W2-1:0] fix_result;
    always_comb begin
        if (reg_div) begin
            fix_result = {res_fix[0][WIDTH-1:0], res_fix[1][WIDTH-1:0]};
        end else begin
            fix_result = res_fix[0];
`ifdef MDU_ACCUM_EN
            if (mdu_is_madd(op_reg)) begin
                fix_result = hilo_reg + res_fix[0];
            end else if (mdu_is_msub(op_reg)) begin
                fix_result = hilo_reg - res_fix[0];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        op_next     = op_reg;
        sign1_next  = sign1_reg;
        sign2_next  = sign2_reg;
        dz_next     = dz_reg;
        result_next = result_reg;
`ifdef MDU_ACCUM_EN
        hilo_next   = hilo_reg;
`endif

        case (state_reg)
            MDU_ST_IDLE: begin
                if (start_i && !annul_i) begin
                    op_next    = op_in;
                    sign1_next = neg1;
                    sign2_next = neg2;
                    cnt_next   = '0;
                    dz_next    = 1'b0;
`ifdef MDU_ACCUM_EN
                    hilo_next  = {hi_i, lo_i};
`endif
                    if (in_div && (opdata2_i == '0)) begin
                        // Nothing to iterate: report immediately.
                        result_next = '0;
                        dz_next     = 1'b1;
                        state_next  = MDU_ST_DONE;
                    end else if (in_div) begin
                        acc_next   = {{WIDTH{1'b0}}, opnd_abs[0]};
                        opnd_next  = opnd_abs[1];
                        state_next = MDU_ST_BUSY;
                    end else begin
                        // Multiplier sits in the low half and is consumed
                        // LSB-first as the product shifts in from the top.
                        acc_next   = {{WIDTH{1'b0}}, opnd_abs[1]};
                        opnd_next  = opnd_abs[0];
                        state_next = MDU_ST_BUSY;
                    end
                end
            end

            MDU_ST_BUSY: begin
                if (annul_i) begin
                    state_next = MDU_ST_IDLE;
                end else begin
                    acc_next = reg_div ? div_step : mul_step;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = MDU_ST_FIX;
                    end
                end
            end

            MDU_ST_FIX: begin
                if (annul_i) begin
                    state_next = MDU_ST_IDLE;
                end else begin
                    result_next = fix_result;
                    state_next  = MDU_ST_DONE;
                end
            end

            MDU_ST_DONE: begin
                state_next = MDU_ST_IDLE;
            end

            default: begin
                state_next = MDU_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= MDU_ST_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            op_reg     <= MDU_MULT;
            sign1_reg  <= 1'b0;
            sign2_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            result_reg <= '0;
`ifdef MDU_ACCUM_EN
            hilo_reg   <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            op_reg     <= op_next;
            sign1_reg  <= sign1_next;
            sign2_reg  <= sign2_next;
            dz_reg     <= dz_next;
            result_reg <= result_next;
`ifdef MDU_ACCUM_EN
            hilo_reg   <= hilo_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign result_o   = result_reg;
    assign ready_o    = (state_reg == MDU_ST_DONE);
    assign busy_o     = (state_reg == MDU_ST_BUSY) || (state_reg == MDU_ST_FIX);
    assign div_zero_o = (state_reg == MDU_ST_DONE) && dz_reg;

endmodule

// File: tb/tb_iter_mdu.sv
// -----------------------------------------------------------------------------
// tb_iter_mdu
// Directed self-checking bench for iter_mdu (WIDTH=32).
// -----------------------------------------------------------------------------
module tb_iter_mdu;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        div_zero_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    iter_mdu dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .div_zero_o (div_zero_o)
    );

    // Present a start for one cycle; returns at the negedge of cycle 1.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hi,
                            input logic [31:0] lo);
        @(negedge clk);
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Bounded wait for ready_o; lat counts cycles after the accepting edge.
    task automatic wait_ready(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (ready_o !== 1'b1 && lat < 200) begin
            if (busy_o === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        $display("txn op=%0d a=%h b=%h hi=%h lo=%h -> result=%h latency=%0d div_zero=%b",
                 op_i, opdata1_i, opdata2_i, hi_i, lo_i, result_o, lat, div_zero_o);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (result_o !== 64'h0) $display("FAIL reset_result: got %h expected %h", result_o, 64'h0); else n_pass++;
        n_total++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
        n_total++; if (div_zero_o !== 1'b0) $display("FAIL reset_divzero: got %b expected 0", div_zero_o); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_mult();
        int lat, bc;
        start_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (lat !== 34) $display("FAIL mult_latency: got %0d expected 34", lat); else n_pass++;
        n_total++; if (bc !== 33) $display("FAIL mult_busy_cycles: got %0d expected 33", bc); else n_pass++;
        n_total++; if (result_o !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL mult_result: got %h expected %h", result_o, 64'hFFFF_FFFF_FFFF_FFFA); else n_pass++;
        n_total++; if (div_zero_o !== 1'b0) $display("FAIL mult_divzero: got %b expected 0", div_zero_o); else n_pass++;
        @(negedge clk);
        n_total++; if (ready_o !== 1'b0) $display("FAIL mult_ready_pulse: got %b expected 0", ready_o); else n_pass++;
        n_total++; if (result_o !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL mult_result_hold: got %h expected %h", result_o, 64'hFFFF_FFFF_FFFF_FFFA); else n_pass++;
        start_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== 64'h4000_0000_0000_0000) $display("FAIL mult_minneg: got %h expected %h", result_o, 64'h4000_0000_0000_0000); else n_pass++;
        start_op(OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== 64'h0000_0001_0000_0000) $display("FAIL multu_result: got %h expected %h", result_o, 64'h0000_0001_0000_0000); else n_pass++;
    endtask

    task automatic test_div();
        int lat, bc;
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (lat !== 34) $display("FAIL div_latency: got %0d expected 34", lat); else n_pass++;
        n_total++; if (result_o !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_signed: got %h expected %h", result_o, 64'hFFFF_FFFF_FFFF_FFFD); else n_pass++;
        start_op(OP_DIVU, 32'd7, 32'd2, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== 64'h0000_0001_0000_0003) $display("FAIL divu_7_2: got %h expected %h", result_o, 64'h0000_0001_0000_0003); else n_pass++;
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== 64'h0000_0000_8000_0000) $display("FAIL div_min_by_m1: got %h expected %h", result_o, 64'h0000_0000_8000_0000); else n_pass++;
    endtask

    task automatic test_div_zero();
        int lat, bc;
        start_op(OP_DIVU, 32'd5, 32'd0, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (lat !== 1) $display("FAIL divzero_latency: got %0d expected 1", lat); else n_pass++;
        n_total++; if (div_zero_o !== 1'b1) $display("FAIL divzero_flag: got %b expected 1", div_zero_o); else n_pass++;
        n_total++; if (result_o !== 64'h0) $display("FAIL divzero_result: got %h expected %h", result_o, 64'h0); else n_pass++;
        @(negedge clk);
        n_total++; if (div_zero_o !== 1'b0 || ready_o !== 1'b0) $display("FAIL divzero_pulse: got dz=%b rdy=%b expected 0/0", div_zero_o, ready_o); else n_pass++;
    endtask

    task automatic test_accum();
        int lat, bc;
        logic [63:0] exp_madd, exp_msub;
`ifdef MDU_ACCUM_EN
        exp_madd = 64'h0000_0001_0000_0001;
        exp_msub = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp_madd = 64'h0000_0000_0000_0002;
        exp_msub = 64'h0000_0000_0000_0001;
`endif
        start_op(OP_MADD, 32'd2, 32'd1, 32'h0, 32'hFFFF_FFFF);
        wait_ready(lat, bc);
        n_total++; if (result_o !== exp_madd) $display("FAIL madd_result: got %h expected %h", result_o, exp_madd); else n_pass++;
        start_op(OP_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== exp_msub) $display("FAIL msubu_result: got %h expected %h", result_o, exp_msub); else n_pass++;
    endtask

    task automatic test_annul();
        int lat, bc, rdy_seen;
        logic [63:0] prev;
        prev = result_o;
        start_op(OP_MULT, 32'd5, 32'd6, 32'h0, 32'h0);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        n_total++; if (busy_o !== 1'b0) $display("FAIL annul_busy: got %b expected 0", busy_o); else n_pass++;
        rdy_seen = 0;
        repeat (40) begin
            if (ready_o === 1'b1) rdy_seen++;
            @(negedge clk);
        end
        n_total++; if (rdy_seen !== 0) $display("FAIL annul_no_ready: got %0d ready cycles expected 0", rdy_seen); else n_pass++;
        n_total++; if (result_o !== prev) $display("FAIL annul_result_kept: got %h expected %h", result_o, prev); else n_pass++;
        // annul together with start in IDLE: start must be refused
        @(negedge clk);
        op_i = OP_DIVU; opdata1_i = 32'd9; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        n_total++; if (busy_o !== 1'b0 || ready_o !== 1'b0) $display("FAIL annul_blocks_start: got busy=%b rdy=%b expected 0/0", busy_o, ready_o); else n_pass++;
        start_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== 64'h0000_0002_0000_000E) $display("FAIL annul_then_divu: got %h expected %h", result_o, 64'h0000_0002_0000_000E); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        start_op(OP_DIVU, 32'd9, 32'd4, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== 64'h0000_0001_0000_0002) $display("FAIL b2b_first: got %h expected %h", result_o, 64'h0000_0001_0000_0002); else n_pass++;
        // start raised during DONE must not be taken until IDLE
        op_i = OP_MULTU; opdata1_i = 32'd3; opdata2_i = 32'd5;
        start_i = 1'b1;
        @(negedge clk);
        n_total++; if (busy_o !== 1'b0) $display("FAIL b2b_done_ignores_start: got busy=%b expected 0", busy_o); else n_pass++;
        @(negedge clk);
        start_i = 1'b0;
        n_total++; if (busy_o !== 1'b1) $display("FAIL b2b_idle_accepts: got busy=%b expected 1", busy_o); else n_pass++;
        wait_ready(lat, bc);
        n_total++; if (lat !== 34 || result_o !== 64'd15) $display("FAIL b2b_second: got lat=%0d result=%h expected 34 / %h", lat, result_o, 64'd15); else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        int lat, bc;
        start_op(OP_MULT, 32'd7, 32'd9, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_total++; if (result_o !== 64'h0 || ready_o !== 1'b0 || busy_o !== 1'b0 || div_zero_o !== 1'b0)
            $display("FAIL async_reset: got result=%h rdy=%b busy=%b dz=%b expected all 0", result_o, ready_o, busy_o, div_zero_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
        wait_ready(lat, bc);
        n_total++; if (result_o !== 64'hFFFF_FFFE_0000_0001) $display("FAIL reset_then_multu: got %h expected %h", result_o, 64'hFFFF_FFFE_0000_0001); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_accum();
        test_annul();
        test_back_to_back();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iter_mdu.md
Name: iter_mdu

Overview:
- Parametrised iterative multiply/divide/accumulate unit for the EX stage.
- Replaces single-cycle combinational multiply and the two-pass cnt/hilo_temp MADD/MSUB scheme with one radix-2 engine.
- Sequencing is driven by a start/ready handshake; EX holds its stall request while busy_o is high.
- Results go back to EX, which writes them to HI/LO.

Parameters:
- WIDTH, 32, operand width in bits; results are 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request; sampled only in IDLE.
- annul_i  in  1  abort in-flight op (branch/exception flush).
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- hi_i  in  WIDTH  forwarded HI (accumulate ops); sampled at start.
- lo_i  in  WIDTH  forwarded LO; sampled at start.
- result_o  out  2*WIDTH  {HI,LO}. Multiply: {high,low} product. Divide: {remainder,quotient}.
- ready_o  out  1  one-cycle pulse; result_o valid.
- busy_o  out  1  high in BUSY and FIX states.
- div_zero_o  out  1  pulses with ready_o when divisor==0.

Behaviour:
- Reset (async, rst low): state=IDLE, counter=0, all datapath regs=0, result_o=0, ready_o=0, busy_o=0, div_zero_o=0.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - start_i=1 and annul_i=0 → latch op_i, hi_i and lo_i, and operand magnitudes. Signed ops take two's-complement abs; sign flags are saved. Counter=0. Next state BUSY.
  - DIV/DIVU with opdata2_i==0 goes straight to DONE. Result is 0 and div_zero_o=1.
- BUSY: one iteration per cycle, counter++.
  - Multiply: shift-add. If multiplier LSB is 1, add multiplicand into the upper half of the 2*WIDTH accumulator, then shift right.
  - Divide: restoring. Shift {rem,quot} left; if rem>=divisor, subtract and set quot LSB.
  - After WIDTH iterations (counter==WIDTH-1 on the final cycle) → FIX.
- FIX (one cycle):
  - Signed product negated if sign1^sign2.
  - Signed quotient negated if sign1^sign2; remainder takes the dividend's sign.
  - MADD*: {hi,lo}+product. MSUB*: {hi,lo}-product. Arithmetic is mod 2^(2*WIDTH).
  - Result registered into result_o. Next state DONE.
- DONE: ready_o=1 for exactly this cycle; result_o holds until the next accepted start. Next state IDLE. start_i is not accepted in DONE.
- Latency from the accepting edge to the ready_o cycle:
  - WIDTH+2 cycles normally (34 at WIDTH=32).
  - 1 cycle for divide-by-zero.
- annul_i:
  - In BUSY/FIX → IDLE next edge; no ready_o; result_o unchanged.
  - In IDLE it blocks start_i.
  - In DONE it is ignored (result already produced).
- start_i while busy_o=1 is ignored; EX holds operands stable under its stall.
- Corner cases:
  - Most-negative operand: abs wraps to 2^(WIDTH-1) and is correct as unsigned.
  - Signed DIV of -2^(WIDTH-1) by -1: quotient wraps to -2^(WIDTH-1), remainder 0.
- No X propagation: all next-state logic is fully assigned.

Optional Feature:
- Macro MDU_ACCUM_EN.
- Defined: ops 4-7 perform accumulate as above.
- Undefined:
  - Accumulate datapath and hi_i/lo_i latches are omitted.
  - ops 4-7 behave as MULT/MULTU (4,6→MULT; 5,7→MULTU).
  - hi_i/lo_i remain ports but are unused.

Decomposition:
- Shared defines package (existing defines.h): MDU op encodings, state encodings, WIDTH default. Add MDU_* constants alongside the existing `EXE_*_OP set.
- One natural sub-module: mdu_sign_fix. Combinational abs-in / negate-out helper, instantiated twice (operand side, result side).

Test Plan:
1. MULT 0xFFFFFFFE × 0x00000003 → after 34 cycles ready_o=1, result_o=0xFFFFFFFF_FFFFFFFA, busy_o high for cycles 1-33.
2. DIV 0xFFFFFFF9 (-7) / 0x00000002 → result_o={0xFFFFFFFF,0xFFFFFFFD} (rem -1, quot -3); DIVU 7/2 → {1,3}.
3. DIVU x / 0 → ready_o and div_zero_o both high on the next cycle, result_o=0.
4. MADD hi=0, lo=0xFFFFFFFF, 2×1 → {0x00000001,0x00000001}; MSUBU hi=0, lo=0, 1×1 → 0xFFFFFFFF_FFFFFFFF. Repeat with MDU_ACCUM_EN undefined: MADD gives plain product 2.
5. annul_i at cycle 10 of a MULT → no ready_o ever; busy_o low next cycle; immediate new DIVU 100/7 completes with {2,14}.
6. rst low mid-BUSY (cycle 5) → all outputs 0 asynchronously; after release, start_i accepted and a fresh MULTU 0xFFFFFFFF×0xFFFFFFFF yields 0xFFFFFFFE_00000001.
